// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the fetch redirect unit.
// No logic; state encoding, PC increment and default reset PC only.
package fetch_redirect_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RESP,
    ST_HOLD,
    ST_DROP,
    ST_FAULT
  } fetch_state_t;

  localparam int unsigned PC_INC           = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: single-outstanding I-cache requests, one-entry buffer to decode, execute redirects.
// Latency: request -> inst_valid 2 cycles min; holds instruction until inst_ready, requests stall on icache_req_ready.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jump_enable,
  input  logic               execute_done,
  input  logic [XLEN-1:0]    jump_target,
  output logic               icache_req_valid,
  input  logic               icache_req_ready,
  output logic [XLEN-1:0]    icache_req_addr,
  input  logic               icache_resp_valid,
  input  logic [INSTR_W-1:0] icache_resp_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [XLEN-1:0]    inst_pc,
  output logic               flush,
  output logic               fetch_fault,
  output logic [CNT_W-1:0]   redirect_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } out_buf_t;

  fetch_state_t      state, state_nxt;
  logic [XLEN-1:0]   pc, req_pc;
  out_buf_t          out_buf;
  logic              redir, misalign, resp_pending;
  logic              req_vld, inst_vld;

  assign redir        = reset & jump_enable & execute_done & ~fetch_fault;
  assign misalign     = redir & (jump_target[1:0] != 2'b00);
  // A redirect that cannot see the response this cycle must drain it in DROP first.
  assign resp_pending = ((state == ST_WAIT_RESP) || (state == ST_DROP)) & ~icache_resp_valid;

  always_comb begin
    state_nxt = state;
    req_vld   = 1'b0;
    inst_vld  = 1'b0;
    if (redir) begin
      if (resp_pending)  state_nxt = ST_DROP;
      else if (misalign) state_nxt = ST_FAULT;
      else               state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          req_vld = 1'b1;
          if (icache_req_ready) state_nxt = ST_WAIT_RESP;
        end
        ST_WAIT_RESP: if (icache_resp_valid) state_nxt = ST_HOLD;
        ST_HOLD: begin
          inst_vld = 1'b1;
          if (inst_ready) state_nxt = ST_IDLE;
        end
        ST_DROP: if (icache_resp_valid) state_nxt = fetch_fault ? ST_FAULT : ST_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      req_pc         <= RESET_PC;
      out_buf        <= '0;
      fetch_fault    <= 1'b0;
      redirect_count <= '0;
    end else begin
      state <= state_nxt;
      if (redir) begin
        out_buf <= '0;
        if (!misalign)       pc <= jump_target;
        if (misalign)        fetch_fault <= 1'b1;
        if (~&redirect_count) redirect_count <= redirect_count + 1'b1;
      end else begin
        if (state == ST_IDLE && icache_req_ready) req_pc <= pc;
        if (state == ST_WAIT_RESP && icache_resp_valid) begin
          out_buf <= '{instr: icache_resp_data, pc: req_pc};
          pc      <= req_pc + XLEN'(PC_INC);
        end
      end
    end
  end

  assign icache_req_valid = req_vld & reset;
  assign icache_req_addr  = pc;
  assign inst_valid       = inst_vld & reset;
  assign inst_data        = out_buf.instr;
  assign inst_pc          = out_buf.pc;
  assign flush            = redir;

endmodule
